load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Multi-cycle load/store stage directly downstream of the ALU. It takes the ALU
//   result as the effective address, plus rs2 store data and funct3. It drives a
//   word-wide ready/valid data-memory port and returns a sign- or zero-extended
//   load result to writeback. The core stalls while the block is busy.
// PARAMETERS
//   WIDTH    32   data/address width; byte-lane logic is fixed at 4 lanes (WIDTH=32 only)
//   TIMEOUT  255  max cycles waiting on mem_ready before a timeout fault; 0 = never time out
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset (asserted when 0)
//   start      in   1      launch access; sampled only in IDLE
//   is_store   in   1      1 = store, 0 = load
//   funct3     in   3      000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only)
//   addr       in   WIDTH  effective address (ALU alu_out)
//   wdata      in   WIDTH  store data (rs2), right-justified
//   mem_req    out  1      memory request valid
//   mem_we     out  1      write enable
//   mem_addr   out  WIDTH  word-aligned address {addr[31:2],2'b00}
//   mem_wmask  out  4      byte-lane write mask
//   mem_wdata  out  WIDTH  store data replicated/shifted onto its lanes
//   mem_rdata  in   WIDTH  read word, valid when mem_req && mem_ready
//   mem_ready  in   1      memory accepts/completes the request this cycle
//   busy       out  1      state != IDLE
//   done       out  1      one-cycle completion pulse (success or fault)
//   rdata      out  WIDTH  extended load data; valid when done && !err && !is_store
//   err        out  1      fault flag, valid with done
//   err_code   out  2      01 misaligned, 10 illegal funct3, 11 timeout, 00 none
// BEHAVIOUR
//   - Reset: state=IDLE, mem_req=0, mem_we=0, mem_wmask=0, mem_addr/mem_wdata=0, done=0,
//     err=0, err_code=00, rdata=0, wait counter=0. Reset asserted mid-access drops mem_req
//     immediately (async). No done is produced for the aborted access.
//   - FSM states are IDLE, ACCESS, RESP, FAULT.
//   - IDLE: on start, latch addr/wdata/funct3/is_store.
//     Illegal funct3 (011,110,111, or 100/101 on a store) -> FAULT with code 10.
//     Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) -> FAULT with code 01.
//     Illegal funct3 takes priority over misaligned.
//     Otherwise -> ACCESS. start while busy is ignored.
//   - ACCESS: mem_req=1; mem_addr/we/wmask/wdata held stable until mem_ready.
//     On the edge where mem_req && mem_ready: capture mem_rdata and go to RESP.
//     Wait counter increments each ACCESS cycle without mem_ready. When the count reaches
//     TIMEOUT (TIMEOUT != 0) -> FAULT with code 11, and mem_req drops the next cycle.
//   - RESP: done=1, err=0, rdata valid -> IDLE. FAULT: done=1, err=1, no memory access -> IDLE.
//   - Latency with zero-wait memory: start at cycle T, mem_req at T+1, done at T+2.
//     Each wait cycle adds 1. A fault in IDLE gives done at T+1.
//   - Store masks: SB = 0001<<addr[1:0]; SH = 0011<<addr[1:0]; SW = 1111.
//     Write data: byte data replicated on all 4 lanes, half on both halves, word unchanged.
//   - Load extend: lane chosen by the latched addr[1:0].
//     LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
//   - done and rdata are registered. rdata holds its value until the next load completes.
//   - A new start is accepted in the cycle after done (IDLE).
// STRUCTURE
//   - lsu_pkg: state encoding, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU),
//     err_code constants (ERR_NONE, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT).
//   - Sub-module lsu_align (combinational): computes wmask and the shifted store data,
//     and the load extend/lane select. The parent holds the FSM, latches and counter.
// TESTING
//   - LW addr=0x100, mem_rdata=0xDEADBEEF, ready at once:
//     mem_req at T+1, done at T+2, rdata=0xDEADBEEF, err=0.
//   - LB addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80;
//     LBU same -> 0x00000080; LHU addr=0x102 -> 0x00008011.
//   - SB addr=0x201, wdata=0x000000A5 -> mem_we=1, mem_wmask=0010, mem_wdata=0xA5A5A5A5,
//     mem_addr=0x200. SH addr=0x202 -> mask 1100.
//   - LW addr=0x102 -> no mem_req, done at T+1, err=1, err_code=01.
//     Store with funct3=100 -> err_code=10.
//   - TIMEOUT=4 and mem_ready held 0 -> done with err_code=11 after 4 ACCESS cycles,
//     then mem_req=0. Also: 3 wait states then ready -> done at T+5.
//   - reset pulled low during ACCESS -> mem_req=0 immediately, busy=0, done never pulses.
//     After release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 and error encodings,
// and the access-legality helpers used when an access is launched.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp,
    StFault
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Unsigned widths only make sense for loads.
  function automatic logic f3_illegal(logic [2:0] f3, logic st);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return st;
      default:          return 1'b1;
    endcase
  endfunction

  function automatic logic f3_misaligned(logic [2:0] f3, logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide ready/valid data-memory port between the load/store unit and data memory.
interface load_store_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [3:0]       mem_wmask;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wmask, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data placement and load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] word,
  output logic [3:0]       wmask,
  output logic [WIDTH-1:0] lane_wdata,
  output logic [WIDTH-1:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  assign lane_byte = word[{addr_lo, 3'b000} +: 8];
  assign lane_half = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    wmask      = 4'b0000;
    lane_wdata = wdata;
    case (funct3)
      F3_B: begin
        wmask      = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      F3_H: begin
        wmask      = 4'b0011 << addr_lo;
        lane_wdata = {2{wdata[15:0]}};
      end
      F3_W:    wmask = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_data = {24'h000000, lane_byte};
      F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_data = {16'h0000, lane_half};
      F3_W:    load_data = word;
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: launches one data-memory access per start, with legality
// checks, wait-state timeout and a registered done/rdata/err result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [WIDTH-1:0]  addr,
  input  logic [WIDTH-1:0]  wdata,
  load_store_unit_if.master mem,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rdata,
  output logic              err,
  output logic [1:0]        err_code
);

  // Counter only needs to reach TIMEOUT-1; the final wait cycle triggers the fault.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]       funct3_q;
  logic             is_store_q;
  logic [1:0]       err_code_q, err_code_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             latch_en, rdata_load;

  logic [3:0]       wmask;
  logic [WIDTH-1:0] lane_wdata, load_data;

  lsu_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .word       (mem.mem_rdata),
    .wmask      (wmask),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    rdata_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_en = 1'b1;
          cnt_d    = '0;
          if (f3_illegal(funct3, is_store)) begin
            state_d    = StFault;
            err_code_d = ERR_ILLEGAL;
          end else if (f3_misaligned(funct3, addr[1:0])) begin
            state_d    = StFault;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d    = StAccess;
            err_code_d = ERR_NONE;
          end
        end
      end
      StAccess: begin
        if (mem.mem_ready) begin
          state_d    = StResp;
          rdata_load = !is_store_q;
        end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
          state_d    = StFault;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp, StFault: state_d = StIdle;
      default:         state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_store_q <= 1'b0;
      err_code_q <= ERR_NONE;
      cnt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
      if (latch_en) begin
        addr_q     <= addr;
        wdata_q    <= wdata;
        funct3_q   <= funct3;
        is_store_q <= is_store;
      end
      if (rdata_load) begin
        rdata_q <= load_data;
      end
    end
  end

  // Outputs decode directly from state so an async reset drops the request at once.
  assign mem.mem_req   = state_q == StAccess;
  assign mem.mem_we    = (state_q == StAccess) && is_store_q;
  assign mem.mem_wmask = ((state_q == StAccess) && is_store_q) ? wmask : 4'b0000;
  assign mem.mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem.mem_wdata = lane_wdata;

  assign busy     = state_q != StIdle;
  assign done     = (state_q == StResp) || (state_q == StFault);
  assign err      = state_q == StFault;
  assign err_code = (state_q == StFault) ? err_code_q : ERR_NONE;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: latency, lane steering, extension, faults, timeout, reset.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic [1:0]  err_code;

  load_store_unit_if #(.WIDTH(32)) mem_if ();

  load_store_unit #(
    .WIDTH   (32),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .is_store (is_store),
    .funct3   (funct3),
    .addr     (addr),
    .wdata    (wdata),
    .mem      (mem_if),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .err      (err),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observations from the most recent run_op.
  bit          saw_req;
  int          req_cnt;
  int          lat;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_mask;
  logic        req_we;
  logic [31:0] got_rdata;
  logic        got_err, req_at_done;
  logic [1:0]  got_code;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 = start cycle. Memory accepts after 'waits' request cycles.
  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word, input int waits);
    int  waited;
    bit  seen;
    waited = 0;
    seen = 0;
    saw_req = 0;
    req_cnt = 0;
    lat = -1;
    start = 1'b1;
    is_store = st;
    funct3 = f3;
    addr = a;
    wdata = wd;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      if (mem_if.mem_req) begin
        req_cnt++;
        if (!saw_req) begin
          saw_req   = 1;
          req_addr  = mem_if.mem_addr;
          req_we    = mem_if.mem_we;
          req_mask  = mem_if.mem_wmask;
          req_wdata = mem_if.mem_wdata;
        end
        if (waited >= waits) begin
          mem_if.mem_ready = 1'b1;
          mem_if.mem_rdata = word;
        end else begin
          mem_if.mem_ready = 1'b0;
          waited++;
        end
      end else begin
        mem_if.mem_ready = 1'b0;
      end
      if (done) begin
        seen        = 1;
        lat         = cyc;
        got_rdata   = rdata;
        got_err     = err;
        got_code    = err_code;
        req_at_done = mem_if.mem_req;
      end else begin
        step();
      end
    end
    mem_if.mem_ready = 1'b0;
    if (!seen) check("done_seen", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  bit done_during_abort;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    is_store = 1'b0;
    funct3 = 3'b000;
    addr = '0;
    wdata = '0;
    mem_if.mem_ready = 1'b0;
    mem_if.mem_rdata = '0;
    step();
    step();
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_req",   32'(mem_if.mem_req), 32'd0);
    check("rst_mask",  32'(mem_if.mem_wmask), 32'd0);
    check("rst_addr",  mem_if.mem_addr, 32'd0);
    check("rst_wdata", mem_if.mem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_code",  32'(err_code), 32'd0);
    reset = 1'b1;
    step();

    // LW, zero-wait memory
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_req_cyc", 32'(req_cnt), 32'd1);
    check("lw_lat",     32'(lat), 32'd2);
    check("lw_rdata",   got_rdata, 32'hDEADBEEF);
    check("lw_err",     32'(got_err), 32'd0);
    check("lw_addr",    req_addr, 32'h100);
    check("lw_we",      32'(req_we), 32'd0);
    check("lw_done_1cy", 32'(done), 32'd0);

    // Load lane select and extension
    run_op(1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    check("lb_rdata", got_rdata, 32'hFFFFFF80);
    run_op(1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0);
    check("lbu_rdata", got_rdata, 32'h00000080);
    run_op(1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 0);
    check("lhu_rdata", got_rdata, 32'h00008011);
    run_op(1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0);
    check("lh_hi_rdata", got_rdata, 32'hFFFF8011);
    run_op(1'b0, 3'b001, 32'h100, 32'h0, 32'h80112233, 0);
    check("lh_lo_rdata", got_rdata, 32'h00002233);
    run_op(1'b0, 3'b000, 32'h101, 32'h0, 32'h80112233, 0);
    check("lb1_rdata", got_rdata, 32'h00000022);

    // Stores; rdata keeps the last load result
    run_op(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 0);
    check("sb_we",    32'(req_we), 32'd1);
    check("sb_mask",  32'(req_mask), 32'b0010);
    check("sb_wdata", req_wdata, 32'hA5A5A5A5);
    check("sb_addr",  req_addr, 32'h200);
    check("sb_lat",   32'(lat), 32'd2);
    check("sb_rdata_hold", got_rdata, 32'h00000022);
    run_op(1'b1, 3'b001, 32'h202, 32'h1234BEEF, 32'h0, 0);
    check("sh_mask",  32'(req_mask), 32'b1100);
    check("sh_wdata", req_wdata, 32'hBEEFBEEF);
    run_op(1'b1, 3'b010, 32'h204, 32'h12345678, 32'h0, 0);
    check("sw_mask",  32'(req_mask), 32'b1111);
    check("sw_wdata", req_wdata, 32'h12345678);
    check("sw_addr",  req_addr, 32'h204);

    // Faults raised in IDLE: no request, done one cycle after start
    run_op(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    check("mis_req",  32'(saw_req), 32'd0);
    check("mis_lat",  32'(lat), 32'd1);
    check("mis_err",  32'(got_err), 32'd1);
    check("mis_code", 32'(got_code), 32'b01);
    run_op(1'b1, 3'b100, 32'h200, 32'h0, 32'h0, 0);
    check("st_bu_code", 32'(got_code), 32'b10);
    check("st_bu_req",  32'(saw_req), 32'd0);
    run_op(1'b0, 3'b011, 32'h200, 32'h0, 32'h0, 0);
    check("f3_011_code", 32'(got_code), 32'b10);
    run_op(1'b0, 3'b110, 32'h103, 32'h0, 32'h0, 0);
    check("ill_prio_code", 32'(got_code), 32'b10);
    run_op(1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0);
    check("lh_mis_code", 32'(got_code), 32'b01);

    // Timeout with memory never ready (TIMEOUT=4)
    run_op(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1000);
    check("to_lat",     32'(lat), 32'd5);
    check("to_reqcnt",  32'(req_cnt), 32'd4);
    check("to_code",    32'(got_code), 32'b11);
    check("to_err",     32'(got_err), 32'd1);
    check("to_req_off", 32'(req_at_done), 32'd0);

    // Three wait states then ready
    run_op(1'b0, 3'b010, 32'h304, 32'h0, 32'hCAFEF00D, 3);
    check("w3_lat",   32'(lat), 32'd5);
    check("w3_rdata", got_rdata, 32'hCAFEF00D);
    check("w3_err",   32'(got_err), 32'd0);

    // Reset mid-access
    start = 1'b1;
    is_store = 1'b0;
    funct3 = 3'b010;
    addr = 32'h400;
    step();
    start = 1'b0;
    step();
    check("abort_req_before", 32'(mem_if.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_req",  32'(mem_if.mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    done_during_abort = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done) done_during_abort = 1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) done_during_abort = 1;
    end
    check("abort_no_done", 32'(done_during_abort), 32'd0);
    run_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("post_rst_lat",   32'(lat), 32'd2);
    check("post_rst_rdata", got_rdata, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
